// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encodings and default operand width shared by the serial adder.
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/serial_adder_fa.sv
// fullAdder: one-bit full-adder cell used as the serial adder's only arithmetic.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic sum,
    output logic Cout
);
    assign sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that produces {Cout,sum} = A + B + Cin, one bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry, fa_sum, fa_cout;
    logic [CW-1:0]    cnt;

    fullAdder u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry),
        .sum (fa_sum),
        .Cout(fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    a_sh  <= A;
                    b_sh  <= B;
                    carry <= Cin;
                    cnt   <= '0;
                end
                RUN: begin
                    // sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        Cout  <= fa_cout;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed scoreboard bench for serial_adder against a plain-arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .sum  (sum),
        .Cout (cout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0, cyc = 0;
    logic [W:0] exp_q[$];
    int         due_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: pops one expected result per done pulse and watches the hold period in between
    initial begin
        logic [W:0] last, e;
        int         due, busy_run;
        bit         hold;
        busy_run = 0;
        hold = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
                hold = 0;
            end else begin
                check("busy_done_overlap", busy & done, 0);
                if (busy) begin
                    busy_run++;
                    hold = 0;
                end
                if (done) begin
                    check("spurious_done", exp_q.size() == 0, 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        due = due_q.pop_front();
                        check("result", {cout, sum}, e);
                        check("latency", cyc, due);
                        check("busy_len", busy_run, W);
                        last = e;
                        hold = 1;
                    end
                    busy_run = 0;
                end else if (!busy && hold) begin
                    check("hold", {cout, sum}, last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", busy || done, 0);
    endtask

    task automatic push_exp(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic c_, input int due);
        logic [W:0] e;
        e = a_ + b_ + c_;
        exp_q.push_back(e);
        due_q.push_back(due);
    endtask

    task automatic issue(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic c_);
        wait_idle();
        a = a_;
        b = b_;
        cin = c_;
        start = 1'b1;
        push_exp(a_, b_, c_, cyc + W + 1);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        issue(8'hFF, 8'h01, 1'b0);
        drain();
        issue(8'h00, 8'h00, 1'b1);
        drain();
        issue(8'hA5, 8'h5A, 1'b1);
        drain();

        // start and operands disturbed in RUN cycle 3 must be ignored
        issue(8'h33, 8'h44, 1'b0);
        repeat (2) tick();
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        tick();
        start = 1'b0;
        drain();
        repeat (12) tick();

        // reset in RUN cycle 4 aborts the operation
        issue(8'h77, 8'h88, 1'b1);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        due_q.delete();
        tick();
        rst = 1'b0;
        issue(8'h12, 8'h34, 1'b0);
        drain();
        repeat (12) tick();

        // start held high: three back-to-back operations, one every W+2 cycles
        wait_idle();
        a = 8'h9C;
        b = 8'h7B;
        cin = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(8'h9C, 8'h7B, 1'b1, cyc + W + 1 + i * (W + 2));
        tick();
        drain();
        start = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 500; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            drain();
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH SHALL default to 8 and give the operand width; the legal range SHALL be WIDTH >= 2.
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock, with all state updated on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide: request to begin an addition, sampled only in IDLE.
REQ-006 Port A SHALL be an input, WIDTH bits wide: operand A, captured when start is accepted.
REQ-007 Port B SHALL be an input, WIDTH bits wide: operand B, captured when start is accepted.
REQ-008 Port Cin SHALL be an input, 1 bit wide: carry-in, captured when start is accepted.
REQ-009 Port sum SHALL be an output, WIDTH bits wide: the result register.
REQ-010 Port Cout SHALL be an output, 1 bit wide: the final carry-out register.
REQ-011 Port busy SHALL be an output, 1 bit wide: high while the state is RUN.
REQ-012 Port done SHALL be an output, 1 bit wide: a one-cycle pulse, high while the state is DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur at edge E0 when start=1; at E0 the block SHALL load the A and B shift registers, set carry to Cin and clear the bit counter.
REQ-015 RUN SHALL process one bit per edge, LSB first, at edges E1..E_WIDTH, through one full-adder cell (A bit, B bit, carry).
REQ-016 At each RUN edge, the sum bit SHALL shift into sum from the MSB end, the carry register SHALL take the cell's carry-out, and the operand registers SHALL shift right.
REQ-017 The bit counter SHALL be $clog2(WIDTH)+1 bits wide, increment once per RUN edge, and never wrap within one operation.
REQ-018 RUN->DONE SHALL occur at E_WIDTH, when the counter reaches WIDTH-1 before that edge; at E_WIDTH, Cout SHALL take the final carry.
REQ-019 DONE->IDLE SHALL occur unconditionally at the next edge, so that done is high for exactly one cycle.
REQ-020 Latency SHALL be WIDTH+1 edges from start acceptance to the done pulse; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; busy and done SHALL never be high together.
REQ-022 start SHALL be ignored in RUN and DONE, with no queuing; A, B and Cin changes after E0 SHALL NOT affect the result.
REQ-023 sum and Cout SHALL be valid from the DONE cycle and SHALL hold through IDLE until the next accepted start; sum is undefined during RUN.
REQ-024 The result SHALL satisfy {Cout,sum} = A + B + Cin, computed modulo 2^(WIDTH+1).
REQ-025 If start is held high continuously, a new operation SHALL begin on the first IDLE edge after DONE.

Reset
REQ-026 While rst=1, the block SHALL immediately force: state=IDLE, sum=0, Cout=0, busy=0, done=0, counter=0, carry=0 and operand registers=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow, and start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-028 A shared header SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The block SHALL instantiate the team's existing 1-bit fullAdder (ports A, B, Cin, sum, Cout) as its sole sub-module; no other arithmetic SHALL be inferred on the datapath.

Verification
REQ-030 With WIDTH=8: A=8'hFF, B=8'h01, Cin=0, start pulse -> busy high for 8 cycles, done at edge 9 after acceptance, sum=8'h00, Cout=1.
REQ-031 A=8'h00, B=8'h00, Cin=1 -> sum=8'h01, Cout=0; A=8'hA5, B=8'h5A, Cin=1 -> sum=8'h00, Cout=1.
REQ-032 Start re-pulsed and operands changed during RUN cycle 3 -> result unchanged from the original operands, exactly one done pulse.
REQ-033 rst asserted during RUN cycle 4 -> all outputs 0 asynchronously and no done pulse; a following start with A=8'h12, B=8'h34 -> sum=8'h46, Cout=0.
REQ-034 Start held high for 3 operations -> a done every 10 cycles, busy and done never overlap, and sum holds between operations.
REQ-035 500 random {A,B,Cin} operations -> every {Cout,sum} matches A+B+Cin on its done pulse.
